// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and default link constants
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int UART_CLKS_PER_BIT = 8;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit FIFO, not fall-through
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign level_o = level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      // The full/empty guards on push and pop keep the level within 0..DEPTH.
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered UART transmitter: FIFO plus start/data/stop serialiser
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic                 pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 baud_last, out_bit;
  logic [DATA_BITS-1:0] shifted;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (tx_valid),
    .data_i  (tx_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  assign out_bit   = MSB_FIRST ? shift_q[DATA_BITS-1] : shift_q[0];
  assign shifted   = MSB_FIRST ? {shift_q[DATA_BITS-2:0], 1'b0} : {1'b0, shift_q[DATA_BITS-1:1]};

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != IDLE) baud_d = baud_last ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        shift_d = fifo_data;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end
      START: if (baud_last) begin
        tx_d    = out_bit;
        shift_d = shifted;
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (baud_last) begin
        if (bit_q == BIT_LAST) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          tx_d    = out_bit;
          shift_d = shifted;
          bit_d   = bit_q + 1'b1;
        end
      end
      STOP: if (baud_last) begin
        // Reloading straight from STOP keeps back-to-back frames contiguous.
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx  = tx_q;
  assign tx_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic       uart_tx, uart_tx2;
  logic       busy, busy2;
  logic [2:0] fifo_level, fifo_level2;

  uart_tx_buffered dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_buffered #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .uart_tx(uart_tx2), .busy(busy2), .fifo_level(fifo_level2)
  );

  always #2 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of buffered bytes and the per-cycle line values of the frame in flight.
  logic [7:0] mq[$];
  bit         lq[$];
  bit         m_tx = 1'b1;
  bit         m_active = 1'b0;
  bit         m_accepted;
  bit         tr_tx[$];
  bit         tr_busy[$];
  int         tr_lvl[$];

  function automatic logic [9:0] frame_bits(input logic [7:0] b, input bit msb);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = msb ? b[7-i] : b[i];
    f[9] = 1'b1;
    return f;
  endfunction

  function automatic void model_edge(input bit v, input logic [7:0] d);
    bit was_full;
    logic [9:0] f;
    was_full   = (mq.size() >= 4);
    m_accepted = 1'b0;
    if (lq.size() == 0 && mq.size() > 0) begin
      f = frame_bits(mq.pop_front(), 1'b1);
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < 8; j++) lq.push_back(f[k]);
    end
    if (v && !was_full) begin
      mq.push_back(d);
      m_accepted = 1'b1;
    end
    if (lq.size() > 0) begin
      m_tx     = lq.pop_front();
      m_active = 1'b1;
    end else begin
      m_tx     = 1'b1;
      m_active = 1'b0;
    end
  endfunction

  function automatic bit model_idle();
    return (mq.size() == 0) && (lq.size() == 0) && !m_active;
  endfunction

  task automatic cyc(input bit v, input logic [7:0] d);
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    chk("uart_tx", 32'(uart_tx), 32'(m_tx));
    chk("busy", 32'(busy), 32'(m_active || (mq.size() > 0)));
    chk("tx_ready", 32'(tx_ready), 32'(mq.size() < 4));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    tr_tx.push_back(uart_tx);
    tr_busy.push_back(busy);
    tr_lvl.push_back(int'(fifo_level));
  endtask

  task automatic clear_trace();
    tr_tx.delete();
    tr_busy.delete();
    tr_lvl.delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!model_idle() && n < 2000) begin
      cyc(1'b0, 8'h00);
      n++;
    end
    chk(tag, 32'(model_idle()), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx"}, 32'(uart_tx), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    int         pat1[10];
    int         ffall, bfall, peak, acc_idx, zeros;
    logic [7:0] d6;
    logic [9:0] f6;

    pat1 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    reset_n   = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid2 = 1'b0;
    tx_data2  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Single 0xA5 from idle.
    clear_trace();
    cyc(1'b1, 8'hA5);
    repeat (84) cyc(1'b0, 8'h00);
    chk("t1_pre_fall", 32'(tr_tx[0]), 32'd1);
    for (int i = 0; i < 80; i++) chk("t1_line", 32'(tr_tx[1+i]), 32'(pat1[i/8]));
    chk("t1_after", 32'(tr_tx[81]), 32'd1);
    bfall = -1;
    for (int i = 1; i < tr_busy.size(); i++)
      if (bfall < 0 && !tr_busy[i]) bfall = i;
    chk("t1_busy_len", 32'(bfall - 1), 32'd80);

    // Three bytes on consecutive cycles run as contiguous frames.
    clear_trace();
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'hFF);
    cyc(1'b1, 8'h3C);
    repeat (250) cyc(1'b0, 8'h00);
    peak = 0;
    ffall = -1;
    bfall = -1;
    foreach (tr_lvl[i]) if (tr_lvl[i] > peak) peak = tr_lvl[i];
    foreach (tr_tx[i]) if (ffall < 0 && !tr_tx[i]) ffall = i;
    for (int i = 0; i < tr_busy.size(); i++)
      if (ffall >= 0 && i > ffall && bfall < 0 && !tr_busy[i]) bfall = i;
    chk("t3_peak_level", 32'(peak), 32'd2);
    chk("t3_busy_span", 32'(bfall - ffall), 32'd240);
    chk("t3_final_level", 32'(tr_lvl[tr_lvl.size()-1]), 32'd0);

    // Holding tx_valid fills the FIFO; the 6th byte waits for the first pop after the stop bit.
    clear_trace();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom));
    chk("t4_ready_full", 32'(tx_ready), 32'd0);
    chk("t4_level_full", 32'(fifo_level), 32'd4);
    d6 = 8'($urandom);
    acc_idx = -1;
    for (int n = 0; n < 200 && acc_idx < 0; n++) begin
      cyc(1'b1, d6);
      if (m_accepted) acc_idx = tr_tx.size() - 1;
    end
    ffall = -1;
    foreach (tr_tx[i]) if (ffall < 0 && !tr_tx[i]) ffall = i;
    chk("t4_accept_delay", 32'(acc_idx - ffall), 32'd81);
    drain("t4_drain");

    // Reset during data bit 3 of frame 1 with two bytes still queued.
    clear_trace();
    cyc(1'b1, 8'hA5);
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22);
    repeat (33) cyc(1'b0, 8'h00);
    chk("t5_queued", 32'(fifo_level), 32'd2);
    chk("t5_mid_bit3", 32'(uart_tx), 32'd0);
    tx_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    mq.delete();
    lq.delete();
    m_tx     = 1'b1;
    m_active = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_idle_outputs("t5_held");
    end
    reset_n = 1'b1;
    clear_trace();
    repeat (100) cyc(1'b0, 8'h00);
    zeros = 0;
    foreach (tr_tx[i]) if (!tr_tx[i]) zeros++;
    chk("t5_no_frame", 32'(zeros), 32'd0);

    // Randomised traffic, dense then sparse.
    for (int i = 0; i < 1200; i++) cyc(1'(($urandom_range(0, 3)) != 0), 8'($urandom));
    for (int i = 0; i < 1200; i++) cyc(1'(($urandom_range(0, 7)) == 0), 8'($urandom));
    drain("rand_drain");
    check_idle_outputs("rand_end");

    // LSB-first instance.
    tx_valid2 = 1'b1;
    tx_data2  = 8'h01;
    @(posedge clk);
    @(negedge clk);
    tx_valid2 = 1'b0;
    chk("t6_pre_fall", 32'(uart_tx2), 32'd1);
    f6 = frame_bits(8'h01, 1'b0);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t6_line", 32'(uart_tx2), 32'(f6[i/8]));
    end
    @(posedge clk);
    @(negedge clk);
    chk("t6_after", 32'(uart_tx2), 32'd1);
    chk("t6_busy_end", 32'(busy2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
